// File: rtl/rr_arbiter_4.sv
// rtl/rr_arbiter_4.sv - 4-way round-robin arbiter with registered one-hot grant
// Optional hold timeout enabled by defining HOLD_TIMEOUT_EN.
module rr_arbiter_4 #(
    parameter int TIMEOUT = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] gnt_id,
    output logic       valid,
    output logic       expired
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] gnt_q, gnt_d;
    logic [1:0] gnt_id_q, gnt_id_d;
    logic [1:0] last_q, last_d;
    logic [3:0] arb_req;
    logic [1:0] winner;
    logic [1:0] scan_idx;
    logic       found;

`ifdef HOLD_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] HOLD_MAX   = CW'(TIMEOUT);
    localparam logic [CW-1:0] HOLD_LIMIT = CW'(TIMEOUT - 1);

    logic [CW-1:0] hold_cnt_q, hold_cnt_d;
    logic          expired_q, expired_d;
    logic          timeout_hit;

    // Counter reads TIMEOUT-1 during the holder's TIMEOUT-th granted cycle.
    assign timeout_hit = (hold_cnt_q >= HOLD_LIMIT);
`endif

    // The holder is masked out; it only competes again once it has released.
    assign arb_req = req & ~gnt_q;

    always_comb begin
        winner   = last_q;
        found    = 1'b0;
        scan_idx = last_q;
        for (int k = 1; k <= 4; k++) begin
            scan_idx = last_q + 2'(k);
            if (!found && arb_req[scan_idx]) begin
                winner = scan_idx;
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        gnt_id_d = gnt_id_q;
        last_d   = last_q;
`ifdef HOLD_TIMEOUT_EN
        hold_cnt_d = hold_cnt_q;
        expired_d  = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d  = BUSY;
                    gnt_d    = 4'b0001 << winner;
                    gnt_id_d = winner;
                    last_d   = winner;
`ifdef HOLD_TIMEOUT_EN
                    hold_cnt_d = '0;
`endif
                end
            end
            BUSY: begin
                if (!(|req)) begin
                    state_d = IDLE;
                    gnt_d   = 4'b0000;
                end else if (!req[gnt_id_q]) begin
                    gnt_d    = 4'b0001 << winner;
                    gnt_id_d = winner;
                    last_d   = winner;
`ifdef HOLD_TIMEOUT_EN
                    hold_cnt_d = '0;
                end else if (timeout_hit && (|arb_req)) begin
                    gnt_d      = 4'b0001 << winner;
                    gnt_id_d   = winner;
                    last_d     = winner;
                    hold_cnt_d = '0;
                    expired_d  = 1'b1;
                end else if (hold_cnt_q != HOLD_MAX) begin
                    hold_cnt_d = hold_cnt_q + CW'(1);
`endif
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = 4'b0000;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            gnt_q    <= 4'b0000;
            gnt_id_q <= 2'd0;
            last_q   <= 2'd3;
`ifdef HOLD_TIMEOUT_EN
            hold_cnt_q <= '0;
            expired_q  <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            gnt_id_q <= gnt_id_d;
            last_q   <= last_d;
`ifdef HOLD_TIMEOUT_EN
            hold_cnt_q <= hold_cnt_d;
            expired_q  <= expired_d;
`endif
        end
    end

    assign gnt    = gnt_q;
    assign gnt_id = gnt_id_q;
    assign valid  = (state_q == BUSY);
`ifdef HOLD_TIMEOUT_EN
    assign expired = expired_q;
`else
    assign expired = 1'b0;
`endif

endmodule

// File: tb/tb_rr_arbiter_4.sv
// tb/tb_rr_arbiter_4.sv - directed self-checking bench for rr_arbiter_4
module tb_rr_arbiter_4;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       valid;
    logic       expired;

    int total_cnt  = 0;
    int passed_cnt = 0;

    rr_arbiter_4 #(.TIMEOUT(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .gnt     (gnt),
        .gnt_id  (gnt_id),
        .valid   (valid),
        .expired (expired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] e_gnt, input logic [1:0] e_id,
                       input logic e_valid, input logic e_exp);
        logic [7:0] obs;
        logic [7:0] exp_v;
        obs   = {expired, valid, gnt_id, gnt};
        exp_v = {e_exp, e_valid, e_id, e_gnt};
        total_cnt++;
        assert (obs === exp_v) passed_cnt++;
        else $error("FAIL %s observed {exp,valid,id,gnt}=%b required=%b", tag, obs, exp_v);
    endtask

    initial begin
        rst_n = 1'b0;
        req   = 4'b0000;
        #1;
        chk("reset_state", 4'b0000, 2'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("idle_no_req", 4'b0000, 2'd0, 1'b0, 1'b0);

        // First arbitration after reset scans from index 0, then hand-over without gap
        req = 4'b1111;
        step();
        chk("first_grant_0", 4'b0001, 2'd0, 1'b1, 1'b0);
        req = 4'b1110;
        step();
        chk("handover_1", 4'b0010, 2'd1, 1'b1, 1'b0);
        step();
        chk("hold_1", 4'b0010, 2'd1, 1'b1, 1'b0);
        req = 4'b0000;
        step();
        chk("release_idle", 4'b0000, 2'd1, 1'b0, 1'b0);
        step();
        chk("idle_id_kept", 4'b0000, 2'd1, 1'b0, 1'b0);

        // Full rotation, each holder releasing after one cycle
        rst_n = 1'b0;
        #1;
        chk("reset_again", 4'b0000, 2'd0, 1'b0, 1'b0);
        #2;
        rst_n = 1'b1;
        req   = 4'b1111;
        step();
        chk("rot_0", 4'b0001, 2'd0, 1'b1, 1'b0);
        req = 4'b1110;
        step();
        chk("rot_1", 4'b0010, 2'd1, 1'b1, 1'b0);
        req = 4'b1101;
        step();
        chk("rot_2", 4'b0100, 2'd2, 1'b1, 1'b0);
        req = 4'b1011;
        step();
        chk("rot_3", 4'b1000, 2'd3, 1'b1, 1'b0);
        req = 4'b0111;
        step();
        chk("rot_wrap_0", 4'b0001, 2'd0, 1'b1, 1'b0);

        // Wrap from LAST=2 in IDLE
        req = 4'b0100;
        step();
        chk("set_last_2", 4'b0100, 2'd2, 1'b1, 1'b0);
        req = 4'b0000;
        step();
        chk("idle_last_2", 4'b0000, 2'd2, 1'b0, 1'b0);
        req = 4'b0011;
        step();
        chk("wrap_grant_0", 4'b0001, 2'd0, 1'b1, 1'b0);
        req = 4'b0000;
        step();
        chk("wrap_idle", 4'b0000, 2'd0, 1'b0, 1'b0);

        // Holder 1 keeps requesting while requester 2 competes
        req = 4'b0010;
        step();
        chk("to_cycle1", 4'b0010, 2'd1, 1'b1, 1'b0);
        req = 4'b0110;
        for (int i = 2; i <= 4; i++) begin
            step();
            chk($sformatf("to_hold_cycle%0d", i), 4'b0010, 2'd1, 1'b1, 1'b0);
        end
        step();
`ifdef HOLD_TIMEOUT_EN
        chk("to_expire", 4'b0100, 2'd2, 1'b1, 1'b1);
        step();
        chk("to_expire_pulse_end", 4'b0100, 2'd2, 1'b1, 1'b0);
        req = 4'b0100;
`else
        chk("to_no_expire", 4'b0010, 2'd1, 1'b1, 1'b0);
        for (int i = 6; i <= 9; i++) begin
            step();
            chk($sformatf("to_hold_cycle%0d", i), 4'b0010, 2'd1, 1'b1, 1'b0);
        end
        req = 4'b0100;
        step();
        chk("to_release_2", 4'b0100, 2'd2, 1'b1, 1'b0);
`endif

        // Asynchronous reset between edges while granting requester 2
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset", 4'b0000, 2'd0, 1'b0, 1'b0);
        #2;
        req   = 4'b1100;
        rst_n = 1'b1;
        step();
        chk("post_reset_scan0", 4'b0100, 2'd2, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", passed_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/rr_arbiter_4.md
RR_ARBITER_4 -- requirements
Module: rr_arbiter_4

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 8, the maximum grant hold in cycles when HOLD_TIMEOUT_EN is defined (legal range 1..255).
REQ-002 The block SHALL have port CLK, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port RST_N, input, 1, the reset: asynchronous, active-low.
REQ-004 The block SHALL have port REQ, input, 4, the request lines, bit i for requester i, level-sensitive, held high while the resource is wanted.
REQ-005 The block SHALL have port GNT, output, 4, the registered one-hot grant, bit i for requester i.
REQ-006 The block SHALL have port GNT_ID, output, 2, the registered binary index of the current grantee.
REQ-007 The block SHALL have port VALID, output, 1, which is high while any grant is active.
REQ-008 The block SHALL have port EXPIRED, output, 1, a one-cycle pulse marking a forced release by timeout.

Function
REQ-009 The block SHALL implement two states: IDLE (no grant) and BUSY (one grant active).
REQ-010 The block SHALL keep an internal 2-bit pointer LAST holding the index of the most recent grantee.
REQ-011 Arbitration SHALL scan REQ starting at index (LAST+1) mod 4, upward, wrapping 3->0; the first set bit wins.
REQ-012 In IDLE, at an edge where REQ != 0: GNT = one-hot(winner), GNT_ID = winner, VALID = 1, LAST = winner, state -> BUSY (1-cycle latency from REQ sampled to GNT visible).
REQ-013 In IDLE with REQ == 0: outputs stay GNT = 0, VALID = 0, GNT_ID unchanged.
REQ-014 In BUSY, while REQ[GNT_ID] = 1 (and no timeout applies), the grant SHALL be held unchanged.
REQ-015 In BUSY, at an edge where REQ[GNT_ID] = 0 and other REQ bits are set, the new winner SHALL be granted on that same edge with no idle cycle.
REQ-016 In BUSY, at an edge where REQ == 0, the block SHALL go to IDLE with GNT = 0 and VALID = 0.
REQ-017 GNT SHALL always be zero or exactly one-hot; when VALID = 1, GNT SHALL equal the decode of GNT_ID (00->0001, 01->0010, 10->0100, 11->1000).
REQ-018 Requests arriving while BUSY SHALL be ignored until the release edge; nothing is queued or latched beyond the REQ level.

Reset
REQ-019 RST_N low SHALL immediately (asynchronously) force GNT = 0, GNT_ID = 0, VALID = 0, EXPIRED = 0, LAST = 3, hold counter = 0, state = IDLE.
REQ-020 After RST_N rises, the first arbitration SHALL occur at the first rising edge with REQ != 0 and SHALL scan from index 0.
REQ-021 Reset asserted mid-grant SHALL drop the grant without an EXPIRED pulse.

Configuration
REQ-022 With macro HOLD_TIMEOUT_EN defined, a hold counter of width clog2(TIMEOUT+1) SHALL behave as follows:
- cleared on every new grant; incremented each BUSY edge the grant is retained; saturates.
- when the holder has had GNT for TIMEOUT cycles, REQ[GNT_ID] = 1, and any other REQ bit is set: re-arbitrate on that edge excluding the holder, and pulse EXPIRED high for exactly one cycle.
- if no other requester exists, the holder keeps the grant, the counter saturates, and there is no EXPIRED pulse until a competitor appears.
REQ-023 With HOLD_TIMEOUT_EN undefined, there SHALL be no counter, grants held indefinitely, and EXPIRED tied to 0.

Verification
REQ-024 Reset, then REQ = 4'b1111: GNT = 0001 one edge later; drop REQ[0] -> next edge GNT = 0010, VALID stays 1 with no gap.
REQ-025 All four requesting, each releasing after one grant cycle and re-raising: GNT sequence 0001, 0010, 0100, 1000, 0001.
REQ-026 Wrap: with LAST = 2 and REQ = 4'b0011 from IDLE -> GNT = 0001, GNT_ID = 0; REQ -> 0 -> IDLE, VALID = 0 next edge.
REQ-027 HOLD_TIMEOUT_EN, TIMEOUT = 4: REQ[1] held and REQ[2] raised -> GNT = 0010 for exactly 4 cycles, then 0100 with EXPIRED = 1 for one cycle; without the macro, GNT stays 0010 and EXPIRED stays 0.
REQ-028 RST_N pulsed low between edges while GNT = 0100 -> GNT = 0 and VALID = 0 immediately; after release with REQ = 4'b1100, grant goes to 0100 (scan from 0).
